// File: rtl/fifo_wr_arbiter.sv
// Write-side round-robin arbiter sharing one async-FIFO push port among N_REQ requesters.
// A grant lasts until a last-flagged beat or MAX_BURST accepted beats; FIFO full stalls the burst.
module fifo_wr_arbiter #(
  parameter int unsigned N_REQ     = 4,
  parameter int unsigned DW        = 8,
  parameter int unsigned MAX_BURST = 16
) (
  input  logic                       i_wr_clk,
  input  logic                       i_wr_rst,
  input  logic [N_REQ-1:0]           i_req_valid,
  input  logic [N_REQ*DW-1:0]        i_req_data,
  input  logic [N_REQ-1:0]           i_req_last,
  output logic [N_REQ-1:0]           o_req_ready,
  input  logic                       i_full,
  output logic                       o_push,
  output logic [DW-1:0]              o_data_in,
  output logic [$clog2(N_REQ)-1:0]   o_grant_id,
  output logic                       o_busy
);

  localparam int unsigned IW = $clog2(N_REQ);
  localparam int unsigned CW = $clog2(MAX_BURST + 1);

  typedef enum logic {StIdle, StBurst} state_t;

  state_t          r_state;
  logic [IW-1:0]   r_rr_ptr;
  logic [IW-1:0]   r_grant_id;
  logic [CW-1:0]   r_beat_cnt;

  logic            w_sel_found;
  logic [IW-1:0]   w_sel_idx;
  logic [IW:0]     w_cand;
  logic            w_gnt_valid;
  logic            w_gnt_last;
  logic [DW-1:0]   w_gnt_data;
  logic            w_accept;
  logic            w_burst_end;
  logic [IW-1:0]   w_next_ptr;

  // First valid requester at or after rr_ptr, wrapping modulo N_REQ.
  always_comb begin
    w_sel_found = 1'b0;
    w_sel_idx   = '0;
    w_cand      = '0;
    for (int i = 0; i < N_REQ; i++) begin
      w_cand = {1'b0, r_rr_ptr} + (IW+1)'(i);
      if (w_cand >= (IW+1)'(N_REQ)) begin
        w_cand = w_cand - (IW+1)'(N_REQ);
      end
      if (!w_sel_found && i_req_valid[w_cand[IW-1:0]]) begin
        w_sel_found = 1'b1;
        w_sel_idx   = w_cand[IW-1:0];
      end
    end
  end

  always_comb begin
    w_gnt_valid = 1'b0;
    w_gnt_last  = 1'b0;
    w_gnt_data  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (r_grant_id == IW'(i)) begin
        w_gnt_valid = i_req_valid[i];
        w_gnt_last  = i_req_last[i];
        w_gnt_data  = i_req_data[i*DW +: DW];
      end
    end
  end

  assign o_busy     = (r_state == StBurst);
  assign o_grant_id = r_grant_id;
  assign o_push     = o_busy & w_gnt_valid & ~i_full;
  assign o_data_in  = o_push ? w_gnt_data : '0;

  always_comb begin
    o_req_ready = '0;
    for (int i = 0; i < N_REQ; i++) begin
      o_req_ready[i] = o_busy && !i_full && (r_grant_id == IW'(i));
    end
  end

  assign w_accept    = o_push;
  assign w_burst_end = w_accept && (w_gnt_last || (r_beat_cnt == CW'(MAX_BURST - 1)));
  assign w_next_ptr  = (r_grant_id == IW'(N_REQ - 1)) ? '0 : r_grant_id + IW'(1);

  always_ff @(posedge i_wr_clk or negedge i_wr_rst) begin
    if (!i_wr_rst) begin
      r_state    <= StIdle;
      r_rr_ptr   <= '0;
      r_grant_id <= '0;
      r_beat_cnt <= '0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (w_sel_found) begin
            r_grant_id <= w_sel_idx;
            r_beat_cnt <= '0;
            r_state    <= StBurst;
          end
        end
        StBurst: begin
          if (w_burst_end) begin
            r_state    <= StIdle;
            r_rr_ptr   <= w_next_ptr;
            r_beat_cnt <= '0;
          end else if (w_accept) begin
            r_beat_cnt <= r_beat_cnt + CW'(1);
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: round-robin order, burst limits, full stalls, reset, valid gaps.
module tb_fifo_wr_arbiter;

  logic        clk;
  logic        rst_n;
  logic [3:0]  valid;
  logic [31:0] data;
  logic [3:0]  last;
  logic [3:0]  ready;
  logic        full;
  logic        push;
  logic [7:0]  data_in;
  logic [1:0]  grant;
  logic        busy;

  int tests = 0;
  int fails = 0;
  int beat [4];

  fifo_wr_arbiter #(
    .N_REQ    (4),
    .DW       (8),
    .MAX_BURST(16)
  ) dut (
    .i_wr_clk   (clk),
    .i_wr_rst   (rst_n),
    .i_req_valid(valid),
    .i_req_data (data),
    .i_req_last (last),
    .o_req_ready(ready),
    .i_full     (full),
    .o_push     (push),
    .o_data_in  (data_in),
    .o_grant_id (grant),
    .o_busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_idle(input string tag);
    #1;
    chk({tag, ".busy"}, 32'(busy), 32'd0);
    chk({tag, ".push"}, 32'(push), 32'd0);
    chk({tag, ".ready"}, 32'(ready), 32'd0);
    chk({tag, ".data"}, 32'(data_in), 32'd0);
  endtask

  task automatic expect_push(input string tag, input int g, input logic [7:0] d);
    logic [3:0] r;
    r = 4'(1 << g);
    #1;
    chk({tag, ".busy"}, 32'(busy), 32'd1);
    chk({tag, ".push"}, 32'(push), 32'd1);
    chk({tag, ".grant"}, 32'(grant), 32'(g));
    chk({tag, ".data"}, 32'(data_in), 32'(d));
    chk({tag, ".ready"}, 32'(ready), 32'(r));
  endtask

  task automatic expect_stall(input string tag, input int g, input logic [3:0] r);
    #1;
    chk({tag, ".busy"}, 32'(busy), 32'd1);
    chk({tag, ".push"}, 32'(push), 32'd0);
    chk({tag, ".grant"}, 32'(grant), 32'(g));
    chk({tag, ".ready"}, 32'(ready), 32'(r));
    chk({tag, ".data"}, 32'(data_in), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    valid = '0;
    data  = '0;
    last  = '0;
    full  = 1'b0;
    #12;
    expect_idle("reset");
    chk("reset.grant", 32'(grant), 32'd0);
    rst_n = 1'b1;

    // Single requester 2, three beats.
    tick(); valid = 4'b0100; data[16 +: 8] = 8'hA1; expect_idle("t1.c0");
    tick(); expect_push("t1.b1", 2, 8'hA1);
    tick(); data[16 +: 8] = 8'hA2; expect_push("t1.b2", 2, 8'hA2);
    tick(); data[16 +: 8] = 8'hA3; last[2] = 1'b1; expect_push("t1.b3", 2, 8'hA3);
    tick(); valid = '0; last = '0; expect_idle("t1.end");
    // rr_ptr is now 3: with 0 and 3 both valid, 3 wins.
    tick(); valid = 4'b1001; last = 4'b1001; data[0 +: 8] = 8'h0B; data[24 +: 8] = 8'h3C;
    expect_idle("t1.rr_arb");
    tick(); expect_push("t1.rr3", 3, 8'h3C);
    tick(); valid = '0; last = '0; expect_idle("t1.rr_end");

    // All four requesters continuously valid, two-beat bursts, from reset.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) beat[i] = 0;
    for (int c = 0; c < 15; c++) begin
      int g;
      tick();
      valid = 4'b1111;
      for (int i = 0; i < 4; i++) begin
        data[i*8 +: 8] = 8'(i*16 + beat[i]);
        last[i] = beat[i][0];
      end
      g = (c / 3) % 4;
      if (c % 3 == 0) begin
        expect_idle($sformatf("t2.c%0d", c));
      end else begin
        expect_push($sformatf("t2.c%0d", c), g, 8'(g*16 + beat[g]));
        beat[g]++;
      end
    end
    tick(); valid = '0; last = '0; expect_idle("t2.end");

    // Requester 1 streams 20 beats without last; requester 2 waits with a single beat.
    tick(); valid = 4'b0110; last = 4'b0100; data[16 +: 8] = 8'hEE; data[8 +: 8] = 8'h40;
    expect_idle("t3.c0");
    for (int k = 0; k < 16; k++) begin
      tick(); data[8 +: 8] = 8'(8'h40 + k);
      expect_push($sformatf("t3.k%0d", k), 1, 8'(8'h40 + k));
    end
    tick(); data[8 +: 8] = 8'h50; expect_idle("t3.cap");
    tick(); expect_push("t3.req2", 2, 8'hEE);
    tick(); valid = 4'b0010; last = '0; expect_idle("t3.gap");
    for (int k = 16; k < 20; k++) begin
      tick(); data[8 +: 8] = 8'(8'h40 + k); last[1] = (k == 19);
      expect_push($sformatf("t3.k%0d", k), 1, 8'(8'h40 + k));
    end
    tick(); valid = '0; last = '0; expect_idle("t3.end");

    // Full on beat 2 of a 4-beat burst for five cycles.
    tick(); valid = 4'b0100; data[16 +: 8] = 8'hC0; expect_idle("t4.c0");
    tick(); expect_push("t4.b0", 2, 8'hC0);
    tick(); data[16 +: 8] = 8'hC1; full = 1'b1; expect_stall("t4.full0", 2, 4'b0000);
    for (int s = 1; s < 5; s++) begin
      tick(); expect_stall($sformatf("t4.full%0d", s), 2, 4'b0000);
    end
    tick(); full = 1'b0; expect_push("t4.b1", 2, 8'hC1);
    tick(); data[16 +: 8] = 8'hC2; expect_push("t4.b2", 2, 8'hC2);
    tick(); data[16 +: 8] = 8'hC3; last[2] = 1'b1; expect_push("t4.b3", 2, 8'hC3);
    tick(); valid = '0; last = '0; expect_idle("t4.end");

    // Reset mid-burst; rr_ptr was 3, so requester 3 holds the grant first.
    tick(); valid = 4'b1001; data[24 +: 8] = 8'hD0; data[0 +: 8] = 8'h0A; expect_idle("t5.c0");
    tick(); expect_push("t5.b0", 3, 8'hD0);
    tick(); data[24 +: 8] = 8'hD1; expect_push("t5.b1", 3, 8'hD1);
    rst_n = 1'b0;
    expect_idle("t5.rst");
    chk("t5.rst.grant", 32'(grant), 32'd0);
    tick(); expect_idle("t5.held");
    rst_n = 1'b1; last[0] = 1'b1;
    tick(); expect_push("t5.regrant", 0, 8'h0A);
    tick(); valid = '0; last = '0; expect_idle("t5.end");

    // Granted requester 1 drops valid for three cycles while requester 3 is valid.
    tick(); valid = 4'b0010; data[8 +: 8] = 8'h60; expect_idle("t6.c0");
    tick(); expect_push("t6.b0", 1, 8'h60);
    tick(); valid = 4'b1000; data[24 +: 8] = 8'h77; last[3] = 1'b1;
    expect_stall("t6.gap0", 1, 4'b0010);
    tick(); expect_stall("t6.gap1", 1, 4'b0010);
    tick(); expect_stall("t6.gap2", 1, 4'b0010);
    tick(); valid = 4'b1010; data[8 +: 8] = 8'h61; last[1] = 1'b1;
    expect_push("t6.b1", 1, 8'h61);
    tick(); last[1] = 1'b0; expect_idle("t6.arb");
    tick(); expect_push("t6.req3", 3, 8'h77);
    tick(); valid = '0; last = '0; expect_idle("t6.end");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
Write-side arbiter that shares the single push port of the async FIFO among N_REQ requesters on the write clock domain. It grants one requester at a time for a burst, which ends at a last-flagged beat or after MAX_BURST beats. Grants rotate round-robin. It forwards the granted requester's data and push to the FIFO and applies FIFO full as backpressure.

Parameters:
N_REQ, 4, number of requesters (2..8)
DW, 8, data width; must equal the width of fifo_pkg::data_t
MAX_BURST, 16, maximum beats per grant before a forced handover (1..255)

Ports:
wr_clk  in  1  write-domain clock
wr_rst  in  1  asynchronous, active-low reset
req_valid  in  N_REQ  per-requester beat valid
req_data  in  N_REQ*DW  per-requester data; requester i occupies bits [i*DW +: DW]
req_last  in  N_REQ  per-requester last-beat-of-burst flag, qualified by req_valid
req_ready  out  N_REQ  per-requester beat accept
full  in  1  FIFO full flag
push  out  1  FIFO push strobe
data_in  out  DW  FIFO write data
grant_id  out  $clog2(N_REQ)  currently granted requester; valid only while busy=1
busy  out  1  a grant is active

Behaviour:
- Reset (wr_rst=0, asynchronous):
  - state=IDLE; rr_ptr=0; grant_id=0; beat_cnt=0.
  - busy=0, push=0, req_ready=0, data_in=0.
  - Reset asserted mid-burst drops the burst immediately; no push is issued in that cycle.
- States: IDLE, BURST.
- IDLE:
  - busy=0, push=0, req_ready=all 0.
  - If any req_valid=1, the edge selects the first requester with valid=1, searching from rr_ptr upward with wrap-around.
  - It registers grant_id, clears beat_cnt and moves to BURST.
  - Arbitration latency: 1 cycle from valid to grant.
- BURST:
  - busy=1.
  - req_ready[grant_id]=!full; every other req_ready=0.
  - push = req_valid[grant_id] & !full (combinational).
  - data_in = req_data slice of grant_id (combinational mux); data_in is 0 when push=0.
  - A beat is accepted when req_valid[grant_id]&req_ready[grant_id]; beat_cnt increments on each accepted beat.
  - Burst end: an accepted beat with req_last=1, or an accepted beat that makes beat_cnt==MAX_BURST. At that edge: state to IDLE, rr_ptr=(grant_id+1) mod N_REQ, beat_cnt=0.
  - The next grant is therefore issued no earlier than 2 cycles after the last beat (one IDLE arbitration cycle). This is fixed behaviour.
  - If the granted requester deasserts valid mid-burst, the grant is held and other requesters wait. No timeout.
  - full=1 stalls the burst: push=0, ready=0, counters frozen. Push never occurs while full=1.
- Width rules:
  - beat_cnt is $clog2(MAX_BURST+1) bits and never exceeds MAX_BURST.
  - rr_ptr and grant_id are $clog2(N_REQ) bits; wrap-around is modulo N_REQ, including non-power-of-2 N_REQ.
- Invariants:
  - At most one req_ready is high.
  - push implies busy and !full.
  - The number of accepted beats equals the number of push cycles.
- req_last on a non-granted requester is ignored.

Test Plan:
- Single requester 2 issues a 3-beat burst, data 0xA1/0xA2/0xA3, last on the third beat, full=0 -> grant_id=2 one cycle after valid; push high 3 consecutive cycles with those data; busy drops after the third beat; rr_ptr=3.
- All 4 requesters valid continuously, 2-beat bursts each, starting from reset -> grant order 0,1,2,3,0; each grant carries exactly 2 pushes; one idle cycle between grants.
- Requester 1 streams 20 beats without last, MAX_BURST=16 -> exactly 16 pushes, then the grant moves to the next valid requester; the remaining 4 beats go out on requester 1's next grant.
- full asserted on beat 2 of a 4-beat burst for 5 cycles -> push=0 and req_ready=0 for those 5 cycles; beat 2 data is pushed on the first cycle after full drops; total pushes=4 with data order preserved.
- wr_rst pulsed low mid-burst after beat 1 of 4 -> push, busy and req_ready go 0 immediately; after release, the first grant goes to requester 0 if valid (rr_ptr reset).
- Granted requester drops valid for 3 cycles while requester 3 is valid -> grant held, no push during the gap, requester 3's req_ready stays 0, and the burst resumes when valid returns.
